// File: rtl/bubble_outbuffer_loader.sv
// Write-side engine for the bubble output buffer: takes a load request, pulls bytes
// from an upstream source and serializes them into one-bit buffer writes.
module bubble_outbuffer_loader #(
    parameter int MSBFIRST = 1
) (
    input  logic        MCLK,
    input  logic        nRESET,
    input  logic        START,
    input  logic [14:0] BASEADDR,
    input  logic [13:0] BITCOUNT,
    input  logic        ABORT,
    output logic        BYTEREQ,
    input  logic        BYTEVALID,
    input  logic [7:0]  BYTEDATA,
    output logic        nOUTBUFWCLKEN,
    output logic [14:0] OUTBUFWADDR,
    output logic        OUTBUFWDATA,
    output logic        BUSY,
    output logic        DONE
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_SHIFT = 3'd2,
        ST_FIN   = 3'd3,
        ST_NULL  = 3'd4
    } state_t;

    state_t      state_q;
    logic [14:0] addr_q;
    logic [13:0] rem_q;
    logic [7:0]  shift_q;
    logic [2:0]  bitidx_q;

    logic        byte_req_q;
    logic        wen_n_q;
    logic [14:0] waddr_q;
    logic        wdata_q;
    logic        busy_q;
    logic        done_q;

    logic [14:0] addr_inc_s;
    logic [13:0] rem_dec_s;
    logic        byte_end_s;

    function automatic logic head_bit(input logic [7:0] b);
        return (MSBFIRST != 0) ? b[7] : b[0];
    endfunction

    function automatic logic [7:0] shift_next(input logic [7:0] b);
        return (MSBFIRST != 0) ? {b[6:0], 1'b0} : {1'b0, b[7:1]};
    endfunction

    assign addr_inc_s = addr_q + 15'd1;
    assign rem_dec_s  = rem_q - 14'd1;
    // bitidx wraps to zero once all eight bits of the byte have been emitted
    assign byte_end_s = (rem_q == 14'd0) || (bitidx_q == 3'd0);

    // Load sequencer; every output is a register updated here.
    always_ff @(posedge MCLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q    <= ST_IDLE;
            addr_q     <= 15'd0;
            rem_q      <= 14'd0;
            shift_q    <= 8'd0;
            bitidx_q   <= 3'd0;
            byte_req_q <= 1'b0;
            wen_n_q    <= 1'b1;
            waddr_q    <= 15'd0;
            wdata_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else if (ABORT) begin
            state_q    <= ST_IDLE;
            byte_req_q <= 1'b0;
            wen_n_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (START) begin
                        if (BITCOUNT != 14'd0) begin
                            addr_q     <= BASEADDR;
                            rem_q      <= BITCOUNT;
                            byte_req_q <= 1'b1;
                            busy_q     <= 1'b1;
                            state_q    <= ST_FETCH;
                        end else begin
                            state_q <= ST_NULL;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    if (BYTEVALID) begin
                        byte_req_q <= 1'b0;
                        wen_n_q    <= 1'b0;
                        waddr_q    <= addr_q;
                        wdata_q    <= head_bit(BYTEDATA);
                        shift_q    <= shift_next(BYTEDATA);
                        addr_q     <= addr_inc_s;
                        rem_q      <= rem_dec_s;
                        bitidx_q   <= 3'd1;
                        state_q    <= ST_SHIFT;
                    end else begin
                        state_q <= ST_FETCH;
                    end
                end
                ST_SHIFT: begin
                    if (byte_end_s) begin
                        wen_n_q <= 1'b1;
                        if (rem_q == 14'd0) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_FIN;
                        end else begin
                            byte_req_q <= 1'b1;
                            state_q    <= ST_FETCH;
                        end
                    end else begin
                        wen_n_q  <= 1'b0;
                        waddr_q  <= addr_q;
                        wdata_q  <= head_bit(shift_q);
                        shift_q  <= shift_next(shift_q);
                        addr_q   <= addr_inc_s;
                        rem_q    <= rem_dec_s;
                        bitidx_q <= bitidx_q + 3'd1;
                    end
                end
                ST_NULL: begin
                    // zero-length load: no writes, DONE one cycle later than the request
                    done_q  <= 1'b1;
                    state_q <= ST_FIN;
                end
                ST_FIN: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    byte_req_q <= 1'b0;
                    wen_n_q    <= 1'b1;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                    state_q    <= ST_IDLE;
                end
            endcase
        end
    end

    assign BYTEREQ       = byte_req_q;
    assign nOUTBUFWCLKEN = wen_n_q;
    assign OUTBUFWADDR   = waddr_q;
    assign OUTBUFWDATA   = wdata_q;
    assign BUSY          = busy_q;
    assign DONE          = done_q;

endmodule

// File: tb/tb_bubble_outbuffer_loader.sv
// Scoreboard bench for bubble_outbuffer_loader: a byte-level model predicts every
// write (address, bit, cycle) and every DONE; a monitor checks them as they appear.
module tb_bubble_outbuffer_loader;

    logic        MCLK = 1'b0;
    logic        nRESET;
    logic        START;
    logic [14:0] BASEADDR;
    logic [13:0] BITCOUNT;
    logic        ABORT;
    logic        BYTEREQ;
    logic        BYTEVALID;
    logic [7:0]  BYTEDATA;
    logic        nOUTBUFWCLKEN;
    logic [14:0] OUTBUFWADDR;
    logic        OUTBUFWDATA;
    logic        BUSY;
    logic        DONE;

    localparam int MSB = 1;

    bubble_outbuffer_loader #(.MSBFIRST(MSB)) dut (
        .MCLK(MCLK), .nRESET(nRESET), .START(START), .BASEADDR(BASEADDR),
        .BITCOUNT(BITCOUNT), .ABORT(ABORT), .BYTEREQ(BYTEREQ), .BYTEVALID(BYTEVALID),
        .BYTEDATA(BYTEDATA), .nOUTBUFWCLKEN(nOUTBUFWCLKEN), .OUTBUFWADDR(OUTBUFWADDR),
        .OUTBUFWDATA(OUTBUFWDATA), .BUSY(BUSY), .DONE(DONE)
    );

    always #5 MCLK = ~MCLK;

    typedef struct packed {
        logic [14:0] addr;
        logic        data;
        int          stamp;
    } wr_t;

    wr_t        exp_wr[$];
    int         exp_done[$];
    logic [7:0] src_bytes[$];
    int         cyc = 0;
    int         n_vec = 0;
    int         n_err = 0;

    always @(posedge MCLK) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every strobe and every DONE pulse must match the head of its queue.
    always @(negedge MCLK) begin
        if (nRESET === 1'b1 && nOUTBUFWCLKEN === 1'b0) begin
            if (exp_wr.size() == 0) begin
                check("unexpected_strobe", 1, 0);
            end else begin
                wr_t e;
                e = exp_wr.pop_front();
                check("wr_addr", OUTBUFWADDR, e.addr);
                check("wr_data", OUTBUFWDATA, e.data);
                check("wr_cycle", cyc, e.stamp);
                check("req_during_strobe", BYTEREQ, 0);
                check("busy_during_strobe", BUSY, 1);
            end
        end
        if (nRESET === 1'b1 && DONE === 1'b1) begin
            if (exp_done.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                check("done_cycle", cyc, exp_done.pop_front());
                check("busy_at_done", BUSY, 0);
            end
        end
    end

    function automatic logic [7:0] next_byte();
        if (src_bytes.size() != 0) return src_bytes.pop_front();
        return 8'($urandom);
    endfunction

    task automatic do_load(input logic [14:0] base, input logic [13:0] cnt, input int dly,
                           input int kill_mode, input int kill_at, input bit from_reset);
        int          rem;
        logic [14:0] a;
        int          c;
        int          exp_req;
        bit          req_seen;
        int          wait_cnt;
        int          strobes;
        int          nreq;
        bit          killed;
        rem = int'(cnt);
        a = base;
        strobes = 0;
        nreq = 0;
        killed = 1'b0;
        req_seen = 1'b0;
        wait_cnt = 0;
        @(negedge MCLK); #1;
        START = 1'b1;
        BASEADDR = base;
        BITCOUNT = cnt;
        if (from_reset) nRESET = 1'b1;
        c = cyc;
        if (cnt == 14'd0) exp_done.push_back(c + 2);
        exp_req = c + 1;
        @(negedge MCLK); #1;
        START = 1'b0;
        for (int it = 0; it < 600; it++) begin
            if (it == 599) check("load_timeout", 1, 0);
            if (cyc == c + 1) begin
                check("busy_after_start", BUSY, (cnt != 14'd0) ? 1 : 0);
                if (cnt == 14'd0) check("no_req_zero_len", BYTEREQ, 0);
            end
            if (BYTEREQ === 1'b1 && !req_seen) begin
                check("req_rise_cycle", cyc, exp_req);
                req_seen = 1'b1;
                nreq++;
                wait_cnt = (dly < 0) ? int'($urandom_range(0, 3)) : dly;
            end
            if (nOUTBUFWCLKEN === 1'b0) strobes++;
            if (kill_mode != 0 && strobes == kill_at) begin
                killed = 1'b1;
                BYTEVALID = 1'b0;
                START = 1'b0;
                exp_wr.delete();
                exp_done.delete();
                if (kill_mode == 1) begin
                    ABORT = 1'b1;
                    @(negedge MCLK); #1;
                    ABORT = 1'b0;
                    check("abort_no_strobe", nOUTBUFWCLKEN, 1);
                    check("abort_busy", BUSY, 0);
                    check("abort_done", DONE, 0);
                    check("abort_req", BYTEREQ, 0);
                end else begin
                    nRESET = 1'b0;
                    #1;
                    check("rst_wen", nOUTBUFWCLKEN, 1);
                    check("rst_addr", OUTBUFWADDR, 0);
                    check("rst_data", OUTBUFWDATA, 0);
                    check("rst_busy", BUSY, 0);
                    check("rst_req", BYTEREQ, 0);
                    @(negedge MCLK); #1;
                    nRESET = 1'b1;
                end
                break;
            end
            if (cnt == 14'd0 ? exp_done.size() == 0
                             : (rem == 0 && exp_wr.size() == 0 && exp_done.size() == 0))
                break;
            START = 1'b0;
            if (BUSY === 1'b1 && (cyc == c + 3 || $urandom_range(0, 7) == 0)) begin
                START = 1'b1;
                BASEADDR = 15'($urandom);
                BITCOUNT = 14'($urandom_range(0, 30));
            end
            BYTEVALID = 1'b0;
            if (BYTEREQ === 1'b1) begin
                if (wait_cnt == 0) begin
                    logic [7:0] b;
                    int k;
                    b = next_byte();
                    BYTEVALID = 1'b1;
                    BYTEDATA = b;
                    k = (rem < 8) ? rem : 8;
                    for (int i = 0; i < k; i++) begin
                        wr_t e;
                        e.addr = a;
                        e.data = (MSB != 0) ? b[7 - i] : b[i];
                        e.stamp = cyc + 1 + i;
                        exp_wr.push_back(e);
                        a = a + 15'd1;
                    end
                    rem -= k;
                    if (rem == 0) exp_done.push_back(cyc + k + 1);
                    req_seen = 1'b0;
                    exp_req = cyc + 9;
                end else begin
                    wait_cnt--;
                end
            end else if ($urandom_range(0, 3) == 0) begin
                BYTEVALID = 1'b1;
                BYTEDATA = 8'($urandom);
            end
            @(negedge MCLK); #1;
        end
        BYTEVALID = 1'b0;
        START = 1'b0;
        if (!killed) check("req_phases", nreq, (int'(cnt) + 7) / 8);
    endtask

    initial begin
        nRESET = 1'b0;
        START = 1'b1;
        BASEADDR = 15'h0004;
        BITCOUNT = 14'd16;
        ABORT = 1'b0;
        BYTEVALID = 1'b0;
        BYTEDATA = 8'h00;
        repeat (3) @(negedge MCLK);
        check("reset_wen", nOUTBUFWCLKEN, 1);
        check("reset_addr", OUTBUFWADDR, 0);
        check("reset_data", OUTBUFWDATA, 0);
        check("reset_req", BYTEREQ, 0);
        check("reset_busy", BUSY, 0);
        check("reset_done", DONE, 0);

        src_bytes = '{8'hA5, 8'h3C};
        do_load(15'h0004, 14'd16, 3, 0, 0, 1'b1);
        src_bytes = '{8'hFF, 8'h80};
        do_load(15'h0100, 14'd11, 0, 0, 0, 1'b0);
        src_bytes = '{8'hC0};
        do_load(15'h7FFE, 14'd4, 1, 0, 0, 1'b0);
        do_load(15'h1234, 14'd0, 0, 0, 0, 1'b0);
        src_bytes.delete();
        do_load(15'h0010, 14'd24, 1, 1, 4, 1'b0);
        repeat (4) @(negedge MCLK);
        do_load(15'h0020, 14'd9, -1, 0, 0, 1'b0);
        do_load(15'h0300, 14'd20, 0, 2, 5, 1'b0);
        repeat (3) @(negedge MCLK);
        do_load(15'h0400, 14'd8, 0, 0, 0, 1'b0);

        for (int n = 0; n < 25; n++) begin
            logic [14:0] base;
            base = ($urandom_range(0, 3) == 0) ? 15'(15'h7FF0 + $urandom_range(0, 15))
                                               : 15'($urandom);
            do_load(base, 14'($urandom_range(0, 40)), -1, 0, 0, 1'b0);
        end

        repeat (5) @(negedge MCLK);
        check("leftover_writes", exp_wr.size(), 0);
        check("leftover_done", exp_done.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
